// File: rtl/fsqrt_table_loader_if.sv
// ---------------------------------------------------------------------------
// fsqrt_table_loader_if
// Bundles the byte-stream input, the table RAM write port and the status
// outputs of the fsqrt table loader.
//   start        : one-cycle pulse that begins a load
//   in_data      : byte from the serial receiver
//   in_valid     : in_data valid this cycle
//   in_ready     : loader accepts a byte this cycle
//   wr_en        : one-cycle table RAM write strobe
//   wr_addr      : table RAM write address (word index)
//   wr_data      : table RAM write data
//   busy         : loading table words or the checksum
//   done         : load finished (held until next start or reset)
//   err          : checksum mismatch, meaningful while done=1
//   words_loaded : words written since the last start
// The master modport is the side that feeds bytes; the slave is the loader.
// ---------------------------------------------------------------------------
interface fsqrt_table_loader_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err, words_loaded
    );
endinterface

// File: rtl/fsqrt_table_loader.sv
// ---------------------------------------------------------------------------
// fsqrt_table_loader
// Receives a byte stream, assembles little-endian 32-bit words and writes
// DEPTH of them into the fsqrt gradient/intercept table RAM, then receives
// a 32-bit checksum and compares it against the mod-2**32 sum of the words.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : fsqrt_table_loader_if slave (byte input, RAM write port, status)
// DEPTH must equal 2**ADDR_W.
// ---------------------------------------------------------------------------
module fsqrt_table_loader #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    fsqrt_table_loader_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    // Index of the final table word; writing it moves us to the checksum.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;      // first three bytes of the current word
    logic [31:0]       sum_q, sum_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wl_q, wl_d;

    logic              in_ready;
    logic              accept;
    logic [31:0]       word;

    // Place byte number idx (0..2) of a word into the partial-word register.
    function automatic logic [23:0] put_byte(input logic [23:0] a,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [23:0] r;
        r = a;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            default: r[23:16] = b;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        sum_d      = sum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        err_d      = err_q;
        wl_d       = wl_q;

        in_ready = (state_q == LOAD) || (state_q == CHECK);
        accept   = bus.in_valid && in_ready;
        // The fourth byte completes the word straight from the input.
        word     = {bus.in_data, asm_q};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = LOAD;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    wl_d       = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    sum_d      = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = wl_q[ADDR_W-1:0];
                        wr_data_d  = word;
                        wl_d       = wl_q + 1'b1;
                        sum_d      = sum_q + word;
                        byte_cnt_d = '0;
                        if (wl_q == LAST_IDX) begin
                            state_d = CHECK;
                        end
                    end else begin
                        asm_d      = put_byte(asm_q, byte_cnt_q, bus.in_data);
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        err_d      = (word != sum_q);
                        byte_cnt_d = '0;
                    end else begin
                        asm_d      = put_byte(asm_q, byte_cnt_q, bus.in_data);
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            sum_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wl_q       <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            sum_q      <= sum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wl_q       <= wl_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.busy         = in_ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = wl_q;

endmodule

// File: doc/fsqrt_table_loader.md
FSQRT_TABLE_LOADER -- requirements
Module: fsqrt_table_loader

Interface
REQ-001 Parameter DEPTH, default 2048, number of 32-bit table words loaded (fsqrt gradient/intercept pairs).
REQ-002 Parameter ADDR_W, default 11, width of wr_addr; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a load.
REQ-006 in_data  input  8  byte from the serial receiver.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  one-cycle table RAM write strobe.
REQ-010 wr_addr  output  ADDR_W  table RAM write address.
REQ-011 wr_data  output  32  table RAM write data.
REQ-012 busy  output  1  high in LOAD and CHECK states.
REQ-013 done  output  1  load finished; held until the next start or reset.
REQ-014 err  output  1  checksum mismatch; valid while done=1.
REQ-015 words_loaded  output  ADDR_W+1  count of words written since the last start.

Function
REQ-016 States SHALL be IDLE, LOAD, CHECK and DONE; rst forces IDLE.
REQ-017 A byte is accepted only in a cycle where in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in LOAD and CHECK.
REQ-018 start in IDLE or DONE SHALL do all of the following on the next edge: enter LOAD, clear done, err, words_loaded, the byte counter and the running sum.
REQ-019 start in LOAD or CHECK SHALL be ignored.
REQ-020 A byte offered in the same cycle as start SHALL NOT be accepted.
REQ-021 Words SHALL be assembled little-endian from four accepted bytes: the first byte goes to [7:0] and the fourth byte to [31:24].
REQ-022 Cycles with in_valid=0 between bytes SHALL NOT affect assembly.
REQ-023 wr_en SHALL pulse high for exactly one cycle on the edge after the fourth byte of a word is accepted.
REQ-024 During that wr_en pulse, wr_data SHALL be the assembled word and wr_addr SHALL be the word index, starting at 0 and incrementing by 1.
REQ-025 words_loaded SHALL increment in the same cycle wr_en is high.
REQ-026 The running sum SHALL equal the sum mod 2**32 of all written words.
REQ-027 When word index DEPTH-1 is written, the state SHALL become CHECK, and wr_addr SHALL NOT wrap to 0 with a further write.
REQ-028 In CHECK, four further bytes SHALL be assembled little-endian as the expected checksum and SHALL NOT be written to the RAM.
REQ-029 On the edge after the fourth checksum byte is accepted, the state SHALL become DONE, done SHALL become 1, and err SHALL become 1 iff the checksum differs from the running sum.
REQ-030 In DONE, busy=0 and in_ready=0; done, err and words_loaded SHALL hold.
REQ-031 wr_en SHALL be 0 in every cycle other than those defined in REQ-023.

Reset
REQ-032 While rst=1, on the next edge: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, words_loaded=0; state IDLE; byte counter and running sum cleared.
REQ-033 rst asserted mid-load SHALL discard any partially assembled word, and no wr_en SHALL occur after the reset edge.
REQ-034 rst SHALL take priority over start in the same cycle.

Verification
REQ-035 Reset: hold rst=1 for 2 cycles with in_valid=1 -> all outputs 0, no byte accepted.
REQ-036 Byte order: start, then bytes 78,56,34,12 hex with 0-3 idle cycles between them -> one wr_en with wr_addr=0 and wr_data=0x12345678 on the edge after byte 4.
REQ-037 Full load: 2048 words w[i]=3*i+1, then the correct checksum sum(w) mod 2**32 -> 2048 wr_en pulses at addresses 0..2047, words_loaded=2048, done=1, err=0, in_ready=0.
REQ-038 Bad checksum: same stream with checksum+1 -> done=1, err=1; the RAM contents match the REQ-037 result.
REQ-039 Abort: rst after 1000 words plus 2 bytes of word 1000 -> no further wr_en, IDLE; a new start then writes the next word to wr_addr=0.
REQ-040 Ignored start: pulse start at word 500 -> load continues uninterrupted, words_loaded is not cleared, and the final result matches REQ-037.
